bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Round-robin arbiter for the shared 32-bit datapath bus. It turns the 32 per-source bus-drive requests into a registered 5-bit `select` for the 32-to-1 bus source mux, plus a one-hot grant vector and a bus-valid flag. A granted source keeps the bus until it releases it, drops its request, or hits a hold timeout. A single-cycle turnaround separates grants.

## Interface
- `NUM_SRC`, 32, number of bus sources; fixed at 32 for this datapath.
- `SEL_W`, 5, width of `select`; equals log2(`NUM_SRC`).
- `MAX_HOLD`, 15, maximum grant length in cycles; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):

- `clock`  in  1  rising-edge clock.
- `clear_n`  in  1  asynchronous active-low reset.
- `req`  in  32  per-source request; level, held while the source wants the bus.
- `release`  in  1  pulse from the current owner ending its transfer; ignored when no grant is active.
- `err_clear`  in  1  clears the `timeout_err` flag.
- `select`  out  5  registered mux select, equal to the index of the current or last owner.
- `grant`  out  32  registered one-hot grant; all zero when the bus is idle.
- `bus_valid`  out  1  high exactly while `grant` is non-zero.
- `timeout_err`  out  1  sticky flag, set on a forced (timeout) release.
- `timeout_src`  out  5  index of the source that timed out, captured when `timeout_err` sets.

## Operation
- Reset values: `select` = 0, `grant` = 0, `bus_valid` = 0, `timeout_err` = 0, `timeout_src` = 0, priority pointer `ptr` = 31, state IDLE, hold counter = 0.
- States:
  - IDLE: no grant.
    - If `req` ≠ 0, the winner is the first set bit searched upward from `ptr`+1, wrapping 31→0.
    - Register `select` = winner, `grant` = 1<<winner, `bus_valid` = 1, hold counter = 1, then go to GRANT.
    - If `req` = 0, stay in IDLE; `select` keeps its last value.
  - GRANT: outputs are held. The arbiter exits to IDLE on the first edge where any of these holds:
    - (a) `release` = 1;
    - (b) `req[select]` = 0;
    - (c) hold counter = `MAX_HOLD`.
  - On exit: `ptr` ← `select`, `grant` ← 0, `bus_valid` ← 0.
  - If not exiting, the hold counter increments by 1.
- Timeout: exit by (c) alone, with neither (a) nor (b), sets `timeout_err` and captures `timeout_src` ← `select`.
- Simultaneous exit conditions: if (a) or (b) coincides with (c), the exit is a normal release and `timeout_err` is not set.
- `err_clear` clears `timeout_err` on the next edge. If a new timeout occurs on the same edge, the set wins and `timeout_src` updates.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle. There is no preemption.
- Hold counter width is $clog2(`MAX_HOLD`+1). It saturates and never wraps.
- Reset mid-grant forces all outputs to their reset values immediately (asynchronous). After reset, arbitration restarts with source 0 at highest priority.

## Timing
- Grant latency: request sampled in IDLE at edge N; `grant`/`select`/`bus_valid` are valid from edge N (registered, visible in cycle N+1).
- A grant lasts a minimum of 1 cycle and a maximum of `MAX_HOLD` cycles.
- Release sampled at edge M → `bus_valid` is low during cycle M+1 (turnaround). The next grant is visible at the earliest after edge M+1.
- Throughput: with continuous requests and 1-cycle grants, one grant every 2 cycles.
- `select` is stable for the whole grant and only changes on the edge that starts a grant. The bus mux needs no hazard handling.

## Structure
- Shared package `bus_pkg`: `NUM_SRC`, `SEL_W`, `MAX_HOLD` default, and the state enum {IDLE, GRANT}. The bus source mux imports the same `SEL_W`.
- One sub-module, `rr_priority_pick`: combinational, with inputs `req[31:0]` and `ptr[4:0]` and outputs `winner[4:0]` and `any`. Implemented by rotating `req` by `ptr`+1, doing a find-first-set, then adding back modulo 32.
- All state lives in the top module: FSM, `ptr`, hold counter, output registers.

## Test plan
- Reset release with `req` = 0x0000_0001 → `grant` = 0x1, `select` = 0, `bus_valid` = 1 one edge later. Then `release` → `bus_valid` = 0 for exactly 1 cycle.
- `req` = 0xFFFF_FFFF held, `release` pulsed every grant → `select` sequence 0,1,…,31,0 (wraps). Grants are separated by exactly one idle cycle.
- Source 5 granted, `req[5]` held, no release, `MAX_HOLD` = 15 → exactly 15 grant cycles, then `timeout_err` = 1 and `timeout_src` = 5. `err_clear` clears it on the next edge.
- `release` and the 15th hold cycle coincide → normal exit, `timeout_err` stays 0. Also, `release` pulsed while in IDLE → no effect.
- Source 3 owns the bus while source 2 requests → source 3 is not preempted. After release, source 2 is granted (wraps past 4…31,0,1).
- `clear_n` asserted mid-grant of source 20 → `grant` = 0, `select` = 0, and `bus_valid` = 0 immediately. After deassertion with `req` = 0x0010_0001, source 0 wins first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 32-source datapath bus: source count, select
// width, default hold limit and the arbiter state encoding. The bus source
// mux imports SEL_W from here so select and mux always agree on width.
package bus_pkg;

  localparam int NUM_SRC      = 32;
  localparam int SEL_W        = 5;
  localparam int DEF_MAX_HOLD = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the winner is the first set request bit
// found searching upward from ptr+1, wrapping 31 -> 0. The request vector is
// rotated so that source ptr+1 lands on bit 0, a find-first-set runs on the
// rotated vector, and the offset is added back modulo NUM_SRC.
module rr_priority_pick
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W:0]       shift;
  logic [NUM_SRC-1:0]   rotated;
  logic [SEL_W-1:0]     first_idx;

  // Rotate, find lowest set bit, then undo the rotation in SEL_W-bit arithmetic
  always_comb begin
    shift     = (SEL_W+1)'(ptr) + (SEL_W+1)'(1);
    rotated   = (req >> shift) | (req << ((SEL_W+1)'(NUM_SRC) - shift));
    any       = |req;
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        first_idx = SEL_W'(i);
      end
    end
    winner = first_idx + ptr + SEL_W'(1);
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter. Turns the per-source requests into a registered
// mux select, a one-hot grant and a bus-valid flag. An owner keeps the bus
// until it releases, drops its request or reaches MAX_HOLD cycles; every
// grant is followed by one idle turnaround cycle. A forced (timeout) exit
// raises a sticky error flag and records the offending source.
// The release input is named bus_release because "release" is a reserved
// word in SystemVerilog.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               bus_release,
  input  logic               err_clear,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_SRC-1:0] grant,
  output logic               bus_valid,
  output logic               timeout_err,
  output logic [SEL_W-1:0]   timeout_src
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e          state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    select_q, select_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic                bus_valid_q, bus_valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic [SEL_W-1:0]    timeout_src_q, timeout_src_d;

  logic [SEL_W-1:0]    pick_winner;
  logic                pick_any;
  logic                exit_normal;
  logic                hold_at_max;

  rr_priority_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign exit_normal = bus_release || !req[select_q];
  assign hold_at_max = (hold_q == HOLD_MAX);

  // Next-state: arbitrate in IDLE, hold and watch the exit conditions in GRANT
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    select_d      = select_q;
    grant_d       = grant_q;
    bus_valid_d   = bus_valid_q;
    timeout_err_d = err_clear ? 1'b0 : timeout_err_q;
    timeout_src_d = timeout_src_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          select_d    = pick_winner;
          grant_d     = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_winner;
          bus_valid_d = 1'b1;
          hold_d      = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (exit_normal || hold_at_max) begin
          state_d     = IDLE;
          ptr_d       = select_q;
          grant_d     = '0;
          bus_valid_d = 1'b0;
          hold_d      = '0;
          if (!exit_normal) begin
            timeout_err_d = 1'b1;
            timeout_src_d = select_q;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset restarts priority at source 0
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= IDLE;
      ptr_q         <= SEL_W'(NUM_SRC - 1);
      hold_q        <= '0;
      select_q      <= '0;
      grant_q       <= '0;
      bus_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      timeout_src_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      select_q      <= select_d;
      grant_q       <= grant_d;
      bus_valid_q   <= bus_valid_d;
      timeout_err_q <= timeout_err_d;
      timeout_src_q <= timeout_src_d;
    end
  end

  assign select      = select_q;
  assign grant       = grant_q;
  assign bus_valid   = bus_valid_q;
  assign timeout_err = timeout_err_q;
  assign timeout_src = timeout_src_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr. A behavioural model tracks the
// owner, rotating pointer and hold count as plain integers; each scenario
// task drives the DUT, advances the model and compares outputs inline.
module tb_bus_arbiter_rr;

  localparam int NSRC = 32;
  localparam int MAXH = 15;

  logic        clock;
  logic        clear_n;
  logic [31:0] req;
  logic        bus_release;
  logic        err_clear;
  logic [4:0]  select;
  logic [31:0] grant;
  logic        bus_valid;
  logic        timeout_err;
  logic [4:0]  timeout_src;

  int vectors;
  int miscompares;

  // Model state
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;
  bit m_err;
  int m_src;

  bus_arbiter_rr #(.MAX_HOLD(MAXH)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .req         (req),
    .bus_release (bus_release),
    .err_clear   (err_clear),
    .select      (select),
    .grant       (grant),
    .bus_valid   (bus_valid),
    .timeout_err (timeout_err),
    .timeout_src (timeout_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [43:0] dut_vec();
    return {select, grant, bus_valid, timeout_err, timeout_src};
  endfunction

  function automatic logic [43:0] exp_vec();
    logic [31:0] g;
    g = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    return {m_sel[4:0], g, (m_owner >= 0), m_err, m_src[4:0]};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 31;
    m_hold  = 0;
    m_sel   = 0;
    m_err   = 1'b0;
    m_src   = 0;
  endtask

  // One clock edge of the arbiter rules, applied to the pre-edge inputs
  task automatic model_tick(input logic [31:0] r, input bit rel, input bit ec);
    bit set_err;
    bit found;
    bit a, b, c;
    int idx;
    set_err = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NSRC; k++) begin
        idx = (m_ptr + k) % NSRC;
        if (!found && r[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_sel   = idx;
          m_hold  = 1;
        end
      end
    end else begin
      a = rel;
      b = !r[m_owner];
      c = (m_hold == MAXH);
      if (a || b || c) begin
        m_ptr = m_owner;
        if (c && !a && !b) set_err = 1'b1;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
    if (ec) m_err = 1'b0;
    if (set_err) begin
      m_err = 1'b1;
      m_src = m_sel;
    end
  endtask

  task automatic tick();
    logic [31:0] r;
    bit rel, ec;
    r   = req;
    rel = bus_release;
    ec  = err_clear;
    @(posedge clock);
    model_tick(r, rel, ec);
    #1;
  endtask

  task automatic do_reset();
    req         = '0;
    bus_release = 1'b0;
    err_clear   = 1'b0;
    clear_n     = 1'b0;
    model_reset();
    #3;
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    clear_n = 1'b0;
    #1;
    vectors++;
    if (dut_vec() !== 44'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %h expected %h", dut_vec(), 44'h0);
    end
    clear_n = 1'b1;
    req = 32'h0000_0001;
    tick();
    vectors++;
    if (grant !== 32'h1 || select !== 5'd0 || bus_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_grant: got grant=%h sel=%0d bv=%b expected grant=1 sel=0 bv=1",
               grant, select, bus_valid);
    end
    bus_release = 1'b1;
    tick();
    bus_release = 1'b0;
    vectors++;
    if (bus_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL turnaround_low: got bv=%b vec=%h expected bv=0 vec=%h",
               bus_valid, dut_vec(), exp_vec());
    end
    tick();
    vectors++;
    if (bus_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL turnaround_one_cycle: got bv=%b vec=%h expected bv=1 vec=%h",
               bus_valid, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req         = 32'hFFFF_FFFF;
    bus_release = 1'b1;
    for (int k = 0; k <= NSRC; k++) begin
      tick();
      vectors++;
      if (bus_valid !== 1'b1 || select !== 5'(k % NSRC) || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL rr_grant_%0d: got bv=%b sel=%0d expected bv=1 sel=%0d",
                 k, bus_valid, select, k % NSRC);
      end
      tick();
      vectors++;
      if (bus_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL rr_gap_%0d: got bv=%b vec=%h expected bv=0 vec=%h",
                 k, bus_valid, dut_vec(), exp_vec());
      end
    end
    bus_release = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    req = 32'h1 << 5;
    cnt = 0;
    for (int i = 0; i < MAXH; i++) begin
      tick();
      if (bus_valid === 1'b1) cnt++;
    end
    vectors++;
    if (cnt !== MAXH) begin
      miscompares++;
      $display("[TB] FAIL timeout_len: got %0d grant cycles expected %0d", cnt, MAXH);
    end
    tick();
    vectors++;
    if (bus_valid !== 1'b0 || timeout_err !== 1'b1 || timeout_src !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL timeout_flag: got bv=%b err=%b src=%0d expected bv=0 err=1 src=5",
               bus_valid, timeout_err, timeout_src);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL err_clear: got err=%b vec=%h expected err=0 vec=%h",
               timeout_err, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_release_at_max();
    do_reset();
    req = 32'h1 << 5;
    tick();
    for (int i = 0; i < MAXH - 1; i++) tick();
    vectors++;
    if (bus_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_15th_cycle: got bv=%b expected bv=1", bus_valid);
    end
    bus_release = 1'b1;
    tick();
    bus_release = 1'b0;
    vectors++;
    if (bus_valid !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_at_max: got bv=%b err=%b expected bv=0 err=0",
               bus_valid, timeout_err);
    end
    req = '0;
    bus_release = 1'b1;
    tick();
    tick();
    bus_release = 1'b0;
    vectors++;
    if (bus_valid !== 1'b0 || select !== 5'd5 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_release: got bv=%b sel=%0d err=%b expected bv=0 sel=5 err=0",
               bus_valid, select, timeout_err);
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 32'h1 << 3;
    tick();
    req = (32'h1 << 3) | (32'h1 << 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (select !== 5'd3 || grant !== (32'h1 << 3)) begin
        miscompares++;
        $display("[TB] FAIL no_preempt_%0d: got sel=%0d grant=%h expected sel=3 grant=%h",
                 i, select, grant, 32'h1 << 3);
      end
    end
    bus_release = 1'b1;
    tick();
    bus_release = 1'b0;
    tick();
    vectors++;
    if (select !== 5'd2 || grant !== (32'h1 << 2) || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL rr_wrap_to_2: got sel=%0d grant=%h expected sel=2 grant=%h",
               select, grant, 32'h1 << 2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 32'h1 << 20;
    tick();
    tick();
    vectors++;
    if (select !== 5'd20 || bus_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL src20_grant: got sel=%0d bv=%b expected sel=20 bv=1", select, bus_valid);
    end
    clear_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 32'h0 || select !== 5'd0 || bus_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got grant=%h sel=%0d bv=%b expected all zero",
               grant, select, bus_valid);
    end
    model_reset();
    req = 32'h0010_0001;
    #2;
    clear_n = 1'b1;
    tick();
    vectors++;
    if (select !== 5'd0 || grant !== 32'h1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL post_reset_priority: got sel=%0d grant=%h expected sel=0 grant=1",
               select, grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        req = $urandom() & $urandom() & $urandom();
      end
      bus_release = ($urandom_range(0, 11) == 0);
      err_clear   = ($urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    bus_release = 1'b0;
    err_clear   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_release_at_max();
    test_no_preempt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
